text_console_ctrl: RTL and testbench
====================================

# text_console_ctrl

Parametrised text-mode console controller: accepts a stream of 8-bit ASCII codes over a valid/ready handshake, interprets printable characters and control codes, and maintains a COLS×ROWS character buffer with an auto-advancing cursor, line wrap, hardware scroll and screen clear. The character renderer reads the buffer through an independent registered read port addressed in logical (on-screen) coordinates. It sits between the character input source and the ASCII-ROM/VGA rendering path.

## Interface
- COLS, 80, characters per line (≥2)
- ROWS, 30, lines per screen (≥2)
- COL_W, $clog2(COLS), column index width (derived)
- ROW_W, $clog2(ROWS), row index width (derived)
- clk  in  1  system clock; single clock domain
- reset  in  1  synchronous, active-high reset
- in_valid  in  1  in_char is valid
- in_char  in  8  ASCII code
- in_ready  out  1  controller can accept in_char this cycle
- rd_col  in  COL_W  renderer read column (logical)
- rd_row  in  ROW_W  renderer read row (logical, 0 = top of screen)
- rd_char  out  8  character at (rd_col, rd_row), registered
- cur_x  out  COL_W  cursor column
- cur_y  out  ROW_W  cursor row (logical)
- scrolled  out  1  one-cycle pulse when a scroll is committed

## Operation
- States: CLEAR (write 0x20 to every cell, physical address 0 to COLS·ROWS−1, one per cycle), IDLE (in_ready=1), CLR_LINE (write 0x20 to the COLS cells of the new bottom physical row, one per cycle).
- Transfer occurs when in_valid && in_ready. in_ready is 1 only in IDLE.
- Physical row = (logical row + top_row) mod ROWS; address = phys_row·COLS + col.
- Printable 0x20–0x7E: write at cursor; if cur_x < COLS−1, cur_x+1; else cur_x=0 and advance line.
- LF 0x0A: cur_x=0, advance line. CR 0x0D: cur_x=0, no line change.
- BS 0x08: if cur_x>0, cur_x−1 and write 0x20 at the new position; at cur_x=0, no-op.
- FF 0x0C: cursor to (0,0), top_row=0, enter CLEAR.
- All other codes (0x00–0x1F except the above, 0x7F–0xFF): accepted and discarded, no state change.
- Advance line: if cur_y < ROWS−1, cur_y+1; else top_row=(top_row+1) mod ROWS, scrolled pulses, enter CLR_LINE, cur_y stays ROWS−1.
- CLEAR and CLR_LINE return to IDLE after their final write.
- Reset: cur_x=0, cur_y=0, top_row=0, scrolled=0, in_ready=0, rd_char=0x20, state CLEAR. Reset asserted in any state, including mid-CLEAR or mid-CLR_LINE, restarts the full clear from address 0.

## Timing
- Accepted character is written and the cursor updated on the same clk edge as the handshake. in_ready falls on the next cycle when the character causes a scroll or is FF.
- scrolled is high for exactly the cycle after the scrolling transfer.
- CLR_LINE lasts COLS cycles; CLEAR lasts COLS·ROWS cycles. After reset is released, in_ready rises COLS·ROWS cycles later.
- Read port: rd_char is valid 1 cycle after rd_col/rd_row are applied. Logical-to-physical mapping uses top_row at address time. Read port is active in every state.
- Simultaneous read and write of the same cell returns the old contents (read-first).
- Renderer reads during CLEAR/CLR_LINE return partially-cleared contents; this is accepted behaviour.

## Structure
- Package text_console_pkg: ASCII_BS, ASCII_LF, ASCII_FF, ASCII_CR, ASCII_SPACE constants and the state enum (CLEAR, IDLE, CLR_LINE).
- Sub-module console_cell_ram: simple dual-port, depth COLS·ROWS × 8, one synchronous write port and one registered read-first read port.
- Modulo arithmetic must be done by compare-and-subtract (wrap at ROWS). Do not use a divider, because ROWS is not a power of two.

## Test plan
- COLS=8, ROWS=4, pulse reset for 1 cycle → in_ready low for exactly 32 cycles, then high; every cell reads 0x20; cur=(0,0).
- Send 'A' (0x41) → cur=(1,0); read (0,0) one cycle later returns 0x41.
- Send 8 printable chars on row 0 → cur=(0,1); read (7,0) returns the 8th char.
- Fill rows 0–3, then send LF on row 3 → scrolled pulses once; in_ready low 8 cycles; logical row 0 shows the former row 1; row 3 reads all 0x20; cur=(0,3).
- Run BS at cur=(3,1) and at cur=(0,1) → cursor moves to (2,1) and cell (2,1)=0x20; the BS at (0,1) causes no change. Send 0x07 → accepted, no change. Send FF → in_ready low 32 cycles, cur=(0,0), screen blank.
- Assert reset on the 3rd cycle of CLR_LINE → cursor and top_row reset; full 32-cycle clear follows; no scrolled pulse after reset.

Source files
------------

// File: rtl/text_console_pkg.sv
// Shared constants, FSM state type and wrap helper for the text console controller.
package text_console_pkg;

  localparam logic [7:0] ASCII_BS    = 8'h08;
  localparam logic [7:0] ASCII_LF    = 8'h0A;
  localparam logic [7:0] ASCII_FF    = 8'h0C;
  localparam logic [7:0] ASCII_CR    = 8'h0D;
  localparam logic [7:0] ASCII_SPACE = 8'h20;
  localparam logic [7:0] ASCII_TILDE = 8'h7E;

  typedef enum logic [1:0] {
    CLEAR    = 2'd0,
    IDLE     = 2'd1,
    CLR_LINE = 2'd2
  } state_e;

  // (a + b) mod m for a, b < m, using compare-and-subtract instead of a divider
  function automatic int unsigned wrap_add(input int unsigned a, input int unsigned b,
                                           input int unsigned m);
    int unsigned s;
    s = a + b;
    if (s >= m) s = s - m;
    return s;
  endfunction

endpackage

// File: rtl/console_cell_ram.sv
// Character buffer: one synchronous write port, one registered read-first read port.
module console_cell_ram
  import text_console_pkg::*;
#(
  parameter int unsigned DEPTH  = 2400,
  parameter int unsigned ADDR_W = 12
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              we_i,
  input  logic [ADDR_W-1:0] waddr_i,
  input  logic [7:0]        wdata_i,
  input  logic [ADDR_W-1:0] raddr_i,
  output logic [7:0]        rdata_o
);

  logic [7:0] mem_q [DEPTH];

  always_ff @(posedge clk) begin
    if (we_i) mem_q[waddr_i] <= wdata_i;
  end

  // Non-blocking read of the array gives old data on a same-cell collision
  always_ff @(posedge clk) begin
    if (reset) rdata_o <= ASCII_SPACE;
    else       rdata_o <= mem_q[raddr_i];
  end

endmodule

// File: rtl/text_console_ctrl.sv
// Text-mode console: interprets an ASCII stream into a COLS x ROWS buffer with
// cursor, line wrap, hardware scroll (rotating top_row) and full-screen clear.
module text_console_ctrl
  import text_console_pkg::*;
#(
  parameter  int unsigned COLS  = 80,
  parameter  int unsigned ROWS  = 30,
  localparam int unsigned COL_W = $clog2(COLS),
  localparam int unsigned ROW_W = $clog2(ROWS)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  input  logic [7:0]       in_char,
  output logic             in_ready,
  input  logic [COL_W-1:0] rd_col,
  input  logic [ROW_W-1:0] rd_row,
  output logic [7:0]       rd_char,
  output logic [COL_W-1:0] cur_x,
  output logic [ROW_W-1:0] cur_y,
  output logic             scrolled
);

  localparam int unsigned DEPTH  = COLS * ROWS;
  localparam int unsigned ADDR_W = $clog2(DEPTH);

  state_e            state_q, state_d;
  logic [COL_W-1:0]  cur_x_q, cur_x_d;
  logic [ROW_W-1:0]  cur_y_q, cur_y_d;
  logic [ROW_W-1:0]  top_row_q, top_row_d;
  logic [ADDR_W-1:0] clr_addr_q, clr_addr_d;
  logic [COL_W-1:0]  clr_col_q, clr_col_d;
  logic              scrolled_q, scrolled_d;
  logic              in_ready_q;

  logic              fire_c;
  logic              adv_c;
  logic              we_c;
  logic [ADDR_W-1:0] waddr_c;
  logic [7:0]        wdata_c;
  logic [ROW_W-1:0]  cur_phys_c;
  logic [ROW_W-1:0]  rd_phys_c;
  logic [ADDR_W-1:0] cur_base_c;
  logic [ADDR_W-1:0] raddr_c;

  function automatic logic [ADDR_W-1:0] row_base(input logic [ROW_W-1:0] row);
    return ADDR_W'(row) * ADDR_W'(COLS);
  endfunction

  assign cur_phys_c = ROW_W'(wrap_add(32'(cur_y_q), 32'(top_row_q), ROWS));
  assign rd_phys_c  = ROW_W'(wrap_add(32'(rd_row), 32'(top_row_q), ROWS));
  assign cur_base_c = row_base(cur_phys_c);
  assign raddr_c    = row_base(rd_phys_c) + ADDR_W'(rd_col);
  assign fire_c     = in_valid && in_ready_q;

  // Next-state, cursor and buffer-write decode
  always_comb begin
    state_d    = state_q;
    cur_x_d    = cur_x_q;
    cur_y_d    = cur_y_q;
    top_row_d  = top_row_q;
    clr_addr_d = clr_addr_q;
    clr_col_d  = clr_col_q;
    scrolled_d = 1'b0;
    adv_c      = 1'b0;
    we_c       = 1'b0;
    waddr_c    = cur_base_c + ADDR_W'(cur_x_q);
    wdata_c    = in_char;

    case (state_q)
      CLEAR: begin
        we_c       = 1'b1;
        waddr_c    = clr_addr_q;
        wdata_c    = ASCII_SPACE;
        clr_addr_d = clr_addr_q + 1'b1;
        if (clr_addr_q == ADDR_W'(DEPTH - 1)) state_d = IDLE;
      end

      CLR_LINE: begin
        we_c       = 1'b1;
        waddr_c    = clr_addr_q;
        wdata_c    = ASCII_SPACE;
        clr_addr_d = clr_addr_q + 1'b1;
        clr_col_d  = clr_col_q + 1'b1;
        if (clr_col_q == COL_W'(COLS - 1)) state_d = IDLE;
      end

      IDLE: begin
        if (fire_c) begin
          if (in_char >= ASCII_SPACE && in_char <= ASCII_TILDE) begin
            we_c = 1'b1;
            if (cur_x_q == COL_W'(COLS - 1)) begin
              cur_x_d = '0;
              adv_c   = 1'b1;
            end else begin
              cur_x_d = cur_x_q + 1'b1;
            end
          end else begin
            case (in_char)
              ASCII_LF: begin
                cur_x_d = '0;
                adv_c   = 1'b1;
              end
              ASCII_CR: cur_x_d = '0;
              ASCII_BS: begin
                if (cur_x_q != '0) begin
                  cur_x_d = cur_x_q - 1'b1;
                  we_c    = 1'b1;
                  waddr_c = cur_base_c + ADDR_W'(cur_x_q - 1'b1);
                  wdata_c = ASCII_SPACE;
                end
              end
              ASCII_FF: begin
                cur_x_d    = '0;
                cur_y_d    = '0;
                top_row_d  = '0;
                clr_addr_d = '0;
                state_d    = CLEAR;
              end
              default: ;
            endcase
          end

          // The row leaving the top becomes the new, blanked bottom row
          if (adv_c) begin
            if (cur_y_q != ROW_W'(ROWS - 1)) begin
              cur_y_d = cur_y_q + 1'b1;
            end else begin
              top_row_d  = ROW_W'(wrap_add(32'(top_row_q), 32'd1, ROWS));
              scrolled_d = 1'b1;
              clr_addr_d = row_base(top_row_q);
              clr_col_d  = '0;
              state_d    = CLR_LINE;
            end
          end
        end
      end

      default: state_d = CLEAR;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= CLEAR;
      cur_x_q    <= '0;
      cur_y_q    <= '0;
      top_row_q  <= '0;
      clr_addr_q <= '0;
      clr_col_q  <= '0;
      scrolled_q <= 1'b0;
      in_ready_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      cur_x_q    <= cur_x_d;
      cur_y_q    <= cur_y_d;
      top_row_q  <= top_row_d;
      clr_addr_q <= clr_addr_d;
      clr_col_q  <= clr_col_d;
      scrolled_q <= scrolled_d;
      in_ready_q <= (state_d == IDLE);
    end
  end

  console_cell_ram #(
    .DEPTH (DEPTH),
    .ADDR_W(ADDR_W)
  ) u_ram (
    .clk    (clk),
    .reset  (reset),
    .we_i   (we_c),
    .waddr_i(waddr_c),
    .wdata_i(wdata_c),
    .raddr_i(raddr_c),
    .rdata_o(rd_char)
  );

  assign in_ready = in_ready_q;
  assign cur_x    = cur_x_q;
  assign cur_y    = cur_y_q;
  assign scrolled = scrolled_q;

endmodule

// File: tb/tb_text_console_ctrl.sv
// Randomised bench for text_console_ctrl against a logical-screen reference model.
module tb_text_console_ctrl;

  localparam int unsigned COLS  = 8;
  localparam int unsigned ROWS  = 4;
  localparam int unsigned COL_W = $clog2(COLS);
  localparam int unsigned ROW_W = $clog2(ROWS);

  logic             clk = 1'b0;
  logic             reset = 1'b0;
  logic             in_valid = 1'b0;
  logic [7:0]       in_char = 8'h00;
  logic             in_ready;
  logic [COL_W-1:0] rd_col = '0;
  logic [ROW_W-1:0] rd_row = '0;
  logic [7:0]       rd_char;
  logic [COL_W-1:0] cur_x;
  logic [ROW_W-1:0] cur_y;
  logic             scrolled;

  int n_cmp = 0;
  int n_bad = 0;

  // Reference model in logical coordinates: row 0 is always the top of screen
  logic [7:0] scr [ROWS][COLS];
  int cx, cy;
  bit m_scroll;
  int m_busy;

  always #5 clk = ~clk;

  text_console_ctrl #(
    .COLS(COLS),
    .ROWS(ROWS)
  ) dut (
    .clk     (clk),
    .reset   (reset),
    .in_valid(in_valid),
    .in_char (in_char),
    .in_ready(in_ready),
    .rd_col  (rd_col),
    .rd_row  (rd_row),
    .rd_char (rd_char),
    .cur_x   (cur_x),
    .cur_y   (cur_y),
    .scrolled(scrolled)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  task automatic model_blank();
    for (int r = 0; r < int'(ROWS); r++)
      for (int c = 0; c < int'(COLS); c++) scr[r][c] = 8'h20;
  endtask

  task automatic model_newline();
    if (cy < int'(ROWS) - 1) begin
      cy++;
    end else begin
      for (int r = 0; r < int'(ROWS) - 1; r++)
        for (int c = 0; c < int'(COLS); c++) scr[r][c] = scr[r+1][c];
      for (int c = 0; c < int'(COLS); c++) scr[ROWS-1][c] = 8'h20;
      m_scroll = 1'b1;
      m_busy   = int'(COLS);
    end
  endtask

  task automatic model_apply(input logic [7:0] ch);
    m_scroll = 1'b0;
    m_busy   = 0;
    if (ch >= 8'h20 && ch <= 8'h7E) begin
      scr[cy][cx] = ch;
      if (cx < int'(COLS) - 1) cx++;
      else begin
        cx = 0;
        model_newline();
      end
    end else if (ch == 8'h0A) begin
      cx = 0;
      model_newline();
    end else if (ch == 8'h0D) begin
      cx = 0;
    end else if (ch == 8'h08) begin
      if (cx > 0) begin
        cx--;
        scr[cy][cx] = 8'h20;
      end
    end else if (ch == 8'h0C) begin
      cx = 0;
      cy = 0;
      model_blank();
      m_busy = int'(COLS * ROWS);
    end
  endtask

  // Count busy cycles while offering junk that must not be accepted
  task automatic wait_ready(input int exp_cycles);
    int n;
    int seen;
    n = 0;
    seen = 0;
    while (in_ready !== 1'b1 && n < 200) begin
      in_valid = 1'b1;
      in_char  = 8'($urandom);
      @(negedge clk);
      n++;
      if (scrolled === 1'b1) seen++;
    end
    in_valid = 1'b0;
    check("busy_len", 32'(n), 32'(exp_cycles));
    check("extra_scroll", 32'(seen), 32'd0);
  endtask

  task automatic send(input logic [7:0] ch, input bit hold_busy);
    int n;
    n = 0;
    while (in_ready !== 1'b1 && n < 100) begin
      @(negedge clk);
      n++;
    end
    if (in_ready !== 1'b1) begin
      check("send_ready_timeout", 32'(in_ready), 32'd1);
      return;
    end
    in_valid = 1'b1;
    in_char  = ch;
    @(negedge clk);
    in_valid = 1'b0;
    in_char  = 8'($urandom);
    model_apply(ch);
    check("cur_x", 32'(cur_x), 32'(cx));
    check("cur_y", 32'(cur_y), 32'(cy));
    check("scrolled", 32'(scrolled), 32'(m_scroll));
    check("ready_after", 32'(in_ready), 32'(m_busy == 0));
    if (m_busy > 0 && !hold_busy) wait_ready(m_busy);
  endtask

  task automatic check_screen(input string tag);
    for (int r = 0; r < int'(ROWS); r++) begin
      for (int c = 0; c < int'(COLS); c++) begin
        rd_col = COL_W'(c);
        rd_row = ROW_W'(r);
        @(negedge clk);
        check(tag, 32'(rd_char), 32'(scr[r][c]));
      end
    end
  endtask

  // Called at a falling edge; one-cycle reset pulse then the full clear
  task automatic do_reset();
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    cx = 0;
    cy = 0;
    model_blank();
    check("rst_ready", 32'(in_ready), 32'd0);
    check("rst_cur_x", 32'(cur_x), 32'd0);
    check("rst_cur_y", 32'(cur_y), 32'd0);
    check("rst_scrolled", 32'(scrolled), 32'd0);
    check("rst_rd_char", 32'(rd_char), 32'h20);
    wait_ready(int'(COLS * ROWS));
  endtask

  function automatic logic [7:0] rnd_print();
    return 8'($urandom_range(32, 126));
  endfunction

  function automatic logic [7:0] rnd_char();
    int r;
    r = $urandom_range(0, 99);
    if (r < 70) return rnd_print();
    if (r < 80) return 8'h0A;
    if (r < 85) return 8'h0D;
    if (r < 92) return 8'h08;
    if (r < 94) return 8'h0C;
    if (r < 97) return 8'($urandom_range(0, 7));
    return 8'($urandom_range(127, 255));
  endfunction

  initial begin
    @(negedge clk);
    do_reset();
    check_screen("blank_after_reset");

    send(8'h41, 1'b0);
    check_screen("first_char");

    for (int i = 0; i < 7; i++) send(rnd_print(), 1'b0);
    check_screen("row0_full");

    for (int i = 0; i < 21; i++) send(rnd_print(), 1'b0);
    send(8'h0A, 1'b0);
    check_screen("after_scroll");

    send(8'h0C, 1'b0);
    send(8'h0A, 1'b0);
    for (int i = 0; i < 3; i++) send(rnd_print(), 1'b0);
    send(8'h08, 1'b0);
    send(8'h0D, 1'b0);
    send(8'h08, 1'b0);
    send(8'h07, 1'b0);
    check_screen("backspace");
    send(8'h0C, 1'b0);
    check_screen("form_feed");

    for (int i = 0; i < 400; i++) begin
      if ($urandom_range(0, 3) == 0) @(negedge clk);
      send(rnd_char(), 1'b0);
      if (i % 100 == 99) check_screen("random");
    end

    // Reset while a line clear is in progress
    while (cy < int'(ROWS) - 1) send(8'h0A, 1'b0);
    send(8'h0A, 1'b1);
    @(negedge clk);
    @(negedge clk);
    check("busy_before_reset", 32'(in_ready), 32'd0);
    do_reset();
    check_screen("reset_mid_clr_line");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish (compared %0d)", n_cmp);
    $fatal(1, "watchdog");
  end

endmodule
